// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-FF synchroniser, 3-sample majority vote, and
// parameterised data width / parity / stop bits with parity, framing and break flags.
module uart_rx_cfg #(
    parameter int BAUD      = 9600,
    parameter int CLK_F     = 50_000_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx_serial,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_busy,
    output logic [2:0]           t_state
);

    localparam int CPB = CLK_F / BAUD;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_HALF  = CW'((CPB - 1) / 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    if (CPB < 8) begin : g_err_cpb
        $error("uart_rx_cfg: CLK_F/BAUD = %0d, must be at least 8", CPB);
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data_bits
        $error("uart_rx_cfg: DATA_BITS = %0d, legal range 5..9", DATA_BITS);
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_parity
        $error("uart_rx_cfg: PARITY = %0d, legal values 0..2", PARITY);
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop_bits
        $error("uart_rx_cfg: STOP_BITS = %0d, legal values 1 or 2", STOP_BITS);
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_DONE     = 3'd5,
        S_BRK_WAIT = 3'd6
    } state_e;

    state_e               state_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic [2:0]           hist_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bit_q;
    logic                 ferr_q;

    logic                 vote;
    logic [DATA_BITS-1:0] shift_d;
    logic                 par_err_d;
    logic                 break_d;

    // Synchroniser and vote history idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 3'b111;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
            sync1_q <= i_rx_serial;
            sync2_q <= sync1_q;
            hist_q  <= {hist_q[1:0], sync2_q};
        end
    end

    assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        par_err_d = 1'b0;
        shift_d   = {vote, shift_q[DATA_BITS-1:1]};
        if (PARITY == 1) begin
            par_err_d = ^{shift_q, par_bit_q};
        end else if (PARITY == 2) begin
            par_err_d = ~^{shift_q, par_bit_q};
        end
        break_d = ferr_q && (shift_q == '0) && ((PARITY == 0) || !par_bit_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            ferr_q       <= 1'b0;
            o_valid      <= 1'b0;
            o_rx_data    <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            cnt_q   <= cnt_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!sync2_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        if (!vote) begin
                            state_q    <= S_DATA;
                            bit_idx_q  <= '0;
                            stop_idx_q <= 1'b0;
                            par_bit_q  <= 1'b0;
                            ferr_q     <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + BW'(1);
                        if (bit_idx_q == BIT_LAST) begin
                            state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        par_bit_q <= vote;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (!vote) begin
                            ferr_q <= 1'b1;
                        end
                        if (stop_idx_q == STOP_LAST) begin
                            state_q <= S_DONE;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    cnt_q        <= '0;
                    o_valid      <= 1'b1;
                    o_rx_data    <= shift_q;
                    o_parity_err <= par_err_d;
                    o_frame_err  <= ferr_q;
                    o_break      <= break_d;
                    // A held-low line after a bad stop bit must not retrigger a start.
                    state_q <= (ferr_q && !sync2_q) ? S_BRK_WAIT : S_IDLE;
                end
                S_BRK_WAIT: begin
                    cnt_q <= '0;
                    if (sync2_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy  = (state_q != S_IDLE);
    assign t_state = state_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance driven
// from a table of directed frames, hand-written corner sequences and random frames.
module tb_uart_rx_cfg;

    localparam int CLK_F = 1_000_000;
    localparam int BAUD  = 100_000;
    localparam int CPB   = CLK_F / BAUD;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       br;
        int         cyc;
    } cap_t;

    typedef struct {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       br;
        logic       pbit;
    } exp_t;

    typedef struct {
        int         which;
        logic [8:0] data;
        logic       pflip;
        logic [1:0] stops;
        int         glitch;
        logic [8:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_br;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a;
    logic       rx_b;

    logic       v_a, pe_a, fe_a, br_a, busy_a;
    logic [7:0] d_a;
    logic [2:0] st_a;
    logic       v_b, pe_b, fe_b, br_b, busy_b;
    logic [6:0] d_b;
    logic [2:0] st_b;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    cap_t cap_a[$];
    cap_t cap_b[$];

    uart_rx_cfg #(.BAUD(BAUD), .CLK_F(CLK_F), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_rx_serial(rx_a),
        .o_valid(v_a), .o_rx_data(d_a), .o_parity_err(pe_a), .o_frame_err(fe_a),
        .o_break(br_a), .o_busy(busy_a), .t_state(st_a)
    );

    uart_rx_cfg #(.BAUD(BAUD), .CLK_F(CLK_F), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_rx_serial(rx_b),
        .o_valid(v_b), .o_rx_data(d_b), .o_parity_err(pe_b), .o_frame_err(fe_b),
        .o_break(br_b), .o_busy(busy_b), .t_state(st_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every o_valid pulse together with the edge number that raised it.
    always @(negedge clk) begin
        if (v_a) cap_a.push_back('{d: {1'b0, d_a}, pe: pe_a, fe: fe_a, br: br_a, cyc: cyc});
        if (v_b) cap_b.push_back('{d: {2'b0, d_b}, pe: pe_b, fe: fe_b, br: br_b, cyc: cyc});
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    function automatic int n_data(input int which);
        return (which == 0) ? 8 : 7;
    endfunction

    function automatic int n_par(input int which);
        return (which == 0) ? 0 : 1;
    endfunction

    function automatic int n_stop(input int which);
        return (which == 0) ? 1 : 2;
    endfunction

    function automatic int qsize(input int which);
        return (which == 0) ? cap_a.size() : cap_b.size();
    endfunction

    // Frame-level model: counts ones arithmetically and applies the flag rules directly.
    function automatic exp_t model(input int which, input logic [8:0] data, input logic pflip,
                                   input logic [1:0] stops);
        exp_t e;
        int   nd, pm, value, ones, pbit;
        nd    = n_data(which);
        pm    = n_par(which);
        value = int'(data) % (1 << nd);
        ones  = 0;
        for (int i = 0; i < nd; i++) ones += (value >> i) & 1;
        pbit  = (pm == 0) ? 0 : ones % 2;
        if (pflip) pbit = 1 - pbit;
        e.d    = 9'(value);
        e.pbit = (pbit != 0);
        e.pe   = (pm != 0) && ((ones + pbit) % 2 == 1);
        e.fe   = !stops[0] || (n_stop(which) == 2 && !stops[1]);
        e.br   = e.fe && (value == 0) && (pm == 0 || pbit == 0);
        return e;
    endfunction

    // Called just after a clock edge; k0 is the first edge that sees the start bit.
    task automatic send_frame(input int which, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops, input int glitch, input int idle_bits,
                              output int k0);
        logic [12:0] line_bits;
        int          nd, np, ns, total;
        logic        v;
        nd = n_data(which);
        np = n_par(which);
        ns = n_stop(which);
        line_bits    = '1;
        line_bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) line_bits[1 + i] = data[i];
        if (np != 0) line_bits[1 + nd] = pbit;
        for (int s = 0; s < ns; s++) line_bits[1 + nd + np + s] = stops[s];
        total = 1 + nd + np + ns;
        k0 = cyc + 1;
        for (int b = 0; b < total; b++) begin
            for (int c = 0; c < CPB; c++) begin
                v = line_bits[b];
                if (glitch >= 0 && b == glitch + 1 && c == CPB / 2 - 1) v = ~v;
                set_line(which, v);
                wait_cyc(1);
            end
        end
        set_line(which, 1'b1);
        if (idle_bits > 0) wait_cyc(idle_bits * CPB);
    endtask

    task automatic check_frame(input int which, input exp_t e, input int k0, input string name);
        cap_t c;
        int   t, nbits, exp_cyc;
        t = 0;
        while (qsize(which) == 0 && t < 3 * CPB) begin
            wait_cyc(1);
            t++;
        end
        // Start seen 2 edges after k0, start centre HALF+1 later, one bit period per
        // remaining bit, then one more edge for the DONE cycle.
        nbits   = n_data(which) + n_par(which) + n_stop(which);
        exp_cyc = k0 + 2 + (CPB - 1) / 2 + 1 + CPB * nbits + 1;
        check({name, "/valid_count"}, qsize(which), 1);
        if (qsize(which) > 0) begin
            if (which == 0) c = cap_a.pop_front();
            else            c = cap_b.pop_front();
            check({name, "/data"}, c.d, e.d);
            check({name, "/parity_err"}, c.pe, e.pe);
            check({name, "/frame_err"}, c.fe, e.fe);
            check({name, "/break"}, c.br, e.br);
            check({name, "/latency"}, c.cyc, exp_cyc);
        end
        cap_a.delete();
        cap_b.delete();
    endtask

    initial begin
        vec_t vecs [0:8];
        exp_t e;
        int   k0, k1;
        exp_t e1;

        vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, -1, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h035, 1'b0, 2'b11, -1, 9'h035, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1, 9'h035, 1'b1, 2'b11, -1, 9'h035, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{0, 9'h03C, 1'b0, 2'b10, -1, 9'h03C, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{0, 9'h05A, 1'b0, 2'b11, -1, 9'h05A, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{0, 9'h000, 1'b0, 2'b00, -1, 9'h000, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1, 9'h000, 1'b0, 2'b01, -1, 9'h000, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1, 9'h07F, 1'b0, 2'b11,  6, 9'h07F, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{0, 9'h096, 1'b0, 2'b11,  3, 9'h096, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        wait_cyc(3);
        check("reset/valid_a", v_a, 1'b0);
        check("reset/data_a", d_a, 8'h00);
        check("reset/flags_a", {pe_a, fe_a, br_a}, 3'b000);
        check("reset/busy_a", busy_a, 1'b0);
        check("reset/state_a", st_a, 3'd0);
        check("reset/data_b", d_b, 7'h00);
        check("reset/state_b", st_b, 3'd0);
        rst_n = 1'b1;
        wait_cyc(2 * CPB);

        for (int i = 0; i < 9; i++) begin
            e = model(vecs[i].which, vecs[i].data, vecs[i].pflip, vecs[i].stops);
            send_frame(vecs[i].which, vecs[i].data, e.pbit, vecs[i].stops, vecs[i].glitch, 2, k0);
            e.d  = vecs[i].exp_d;
            e.pe = vecs[i].exp_pe;
            e.fe = vecs[i].exp_fe;
            e.br = vecs[i].exp_br;
            check_frame(vecs[i].which, e, k0, $sformatf("vec%0d", i));
        end

        // Idle-line glitch: no frame, back to IDLE, previous data held.
        rx_a = 1'b0;
        wait_cyc(1);
        rx_a = 1'b1;
        wait_cyc(3 * CPB);
        check("glitch/no_valid", cap_a.size(), 0);
        check("glitch/state", st_a, 3'd0);
        check("glitch/busy", busy_a, 1'b0);
        check("glitch/data_hold", d_a, 8'h96);

        // Back-to-back frames with no idle time between them.
        e  = model(0, 9'h081, 1'b0, 2'b11);
        e1 = model(0, 9'h07E, 1'b0, 2'b11);
        send_frame(0, 9'h081, 1'b0, 2'b11, -1, 0, k0);
        check_frame(0, e, k0, "b2b_first");
        send_frame(0, 9'h07E, 1'b0, 2'b11, -1, 2, k1);
        check_frame(0, e1, k1, "b2b_second");

        // Line held low for 30 bit times.
        rx_a = 1'b0;
        k0   = cyc + 1;
        wait_cyc(15 * CPB);
        check("brk/state_mid", st_a, 3'd6);
        check("brk/busy_mid", busy_a, 1'b1);
        wait_cyc(15 * CPB);
        check("brk/state_end", st_a, 3'd6);
        check("brk/one_valid", cap_a.size(), 1);
        rx_a = 1'b1;
        wait_cyc(2 * CPB);
        check("brk/state_idle", st_a, 3'd0);
        e = model(0, 9'h000, 1'b0, 2'b00);
        check_frame(0, e, k0, "brk");

        // Random frames against the model.
        for (int i = 0; i < 24; i++) begin
            int         w, g;
            logic [8:0] data;
            logic [1:0] stops;
            logic       pflip;
            w        = int'($urandom_range(0, 1));
            data     = 9'($urandom);
            stops[0] = ($urandom_range(0, 4) != 0);
            stops[1] = ($urandom_range(0, 4) != 0);
            pflip    = (w == 1) && ($urandom_range(0, 3) == 0);
            g        = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n_data(w) - 1)) : -1;
            e = model(w, data, pflip, stops);
            send_frame(w, data, e.pbit, stops, g, 2, k0);
            check_frame(w, e, k0, $sformatf("rand%0d", i));
        end

        // Reset in the middle of a frame, after a frame that left a flag set.
        e = model(0, 9'h03C, 1'b0, 2'b10);
        send_frame(0, 9'h03C, 1'b0, 2'b10, -1, 2, k0);
        check_frame(0, e, k0, "pre_reset");
        rx_a = 1'b0;
        wait_cyc(3 * CPB);
        check("midrst/state_data", st_a, 3'd2);
        check("midrst/busy", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst/state", st_a, 3'd0);
        check("midrst/data", d_a, 8'h00);
        check("midrst/frame_err", fe_a, 1'b0);
        check("midrst/busy_low", busy_a, 1'b0);
        wait_cyc(2);
        rx_a  = 1'b1;
        rst_n = 1'b1;
        wait_cyc(2 * CPB);
        check("midrst/no_valid", cap_a.size(), 0);
        e = model(0, 9'h05A, 1'b0, 2'b11);
        send_frame(0, 9'h05A, 1'b0, 2'b11, -1, 2, k0);
        check_frame(0, e, k0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
